// File: rtl/sta_tile_scheduler_pkg.sv
// rtl/sta_tile_scheduler_pkg.sv - shared types, widths and helpers for the tile scheduler
package sta_tile_scheduler_pkg;

  localparam int SA_N        = 4;
  localparam int OC_MAX_DEF  = 512;
  localparam int NUM_CH_DEF  = 64;
  localparam int COORD_BITS  = $clog2(OC_MAX_DEF + 1);
  localparam int CHAN_BITS   = $clog2(NUM_CH_DEF + 1);

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [31:0] int32_t;
  typedef logic [COORD_BITS-1:0] coord_t;
  typedef logic [CHAN_BITS-1:0]  chan_t;

  typedef enum logic [2:0] {IDLE, ISSUE, FEED, DRAIN, NEXT, FIN} sched_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sta_tile_scheduler_tile_coord_counter.sv
// rtl/sta_tile_scheduler_tile_coord_counter.sv - nested col/row/channel stepper with wrap limits and last flag
module tile_coord_counter
  import sta_tile_scheduler_pkg::*;
#(
  parameter int N_BITS  = 10,
  parameter int CH_BITS = 7,
  parameter int STEP    = SA_N
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic [N_BITS-1:0]  lim_cols,
  input  logic [N_BITS-1:0]  lim_rows,
  input  logic [CH_BITS-1:0] lim_ch,
  output logic [N_BITS-1:0]  col,
  output logic [N_BITS-1:0]  row,
  output logic [CH_BITS-1:0] ch,
  output logic               last
);

  logic [N_BITS-1:0]  col_q, col_d, row_q, row_d;
  logic [CH_BITS-1:0] ch_q, ch_d;
  logic [N_BITS:0]    col_sum, row_sum;
  logic [CH_BITS:0]   ch_sum;
  logic               col_wrap, row_wrap;

  // Next coordinate (col innermost); sums carry one extra bit so the limit compare never wraps.
  always_comb begin
    col_sum  = {1'b0, col_q} + (N_BITS+1)'(STEP);
    row_sum  = {1'b0, row_q} + (N_BITS+1)'(STEP);
    ch_sum   = {1'b0, ch_q} + (CH_BITS+1)'(1);
    col_wrap = col_sum >= {1'b0, lim_cols};
    row_wrap = row_sum >= {1'b0, lim_rows};
    last     = col_wrap && row_wrap && (ch_sum >= {1'b0, lim_ch});
    col_d    = col_q;
    row_d    = row_q;
    ch_d     = ch_q;
    if (clear || (step && last)) begin
      col_d = '0;
      row_d = '0;
      ch_d  = '0;
    end else if (step) begin
      if (!col_wrap) begin
        col_d = col_sum[N_BITS-1:0];
      end else begin
        col_d = '0;
        if (!row_wrap) begin
          row_d = row_sum[N_BITS-1:0];
        end else begin
          row_d = '0;
          ch_d  = ch_sum[CH_BITS-1:0];
        end
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ch_q  <= ch_d;
    end
  end

  assign col = col_q;
  assign row = row_q;
  assign ch  = ch_q;

endmodule

// File: rtl/sta_tile_scheduler.sv
// rtl/sta_tile_scheduler.sv - walks output tiles and sequences STA issue/feed/drain; STA_SCHED_PERF_EN adds perf counters
module sta_tile_scheduler
  import sta_tile_scheduler_pkg::*;
#(
  parameter int OC_MAX_N     = 512,
  parameter int NUM_CH       = 64,
  parameter int K_BITS       = 12,
  parameter int DRAIN_CYCLES = 3*SA_N-2,
  localparam int N_BITS      = $clog2(OC_MAX_N + 1),
  localparam int CH_BITS     = $clog2(NUM_CH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               start,
  input  logic [N_BITS-1:0]  cfg_out_rows,
  input  logic [N_BITS-1:0]  cfg_out_cols,
  input  logic [CH_BITS-1:0] cfg_num_ch,
  input  logic [K_BITS-1:0]  cfg_k_beats,
  input  logic               buf_ready,
  output logic               busy,
  output logic               done,
  output logic               tile_valid,
  output logic [N_BITS-1:0]  tile_mat_size,
  output logic [N_BITS-1:0]  tile_pos_row,
  output logic [N_BITS-1:0]  tile_pos_col,
  output logic [CH_BITS-1:0] tile_channel,
  output logic               load_bias,
  output logic               feed_en,
  output logic               sta_stall
`ifdef STA_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_busy_cycles,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_starve_cycles
`endif
);

  localparam int D_BITS = $clog2(DRAIN_CYCLES + 1);

  sched_state_t       state_q, state_d;
  logic [N_BITS-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [CH_BITS-1:0] nch_q, nch_d;
  logic [K_BITS-1:0]  kb_q, kb_d, beat_q, beat_d;
  logic [D_BITS-1:0]  drain_q, drain_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               coord_clear, coord_step, coord_last;

  tile_coord_counter #(.N_BITS(N_BITS), .CH_BITS(CH_BITS), .STEP(SA_N)) u_coord (
    .clk      (clk),
    .reset    (reset),
    .clear    (coord_clear),
    .step     (coord_step),
    .lim_cols (cols_q),
    .lim_rows (rows_q),
    .lim_ch   (nch_q),
    .col      (tile_pos_col),
    .row      (tile_pos_row),
    .ch       (tile_channel),
    .last     (coord_last)
  );

  // Next-state, beat/drain counting and strobes; a stall freezes everything including pending pulses.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    nch_d       = nch_q;
    kb_d        = kb_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = stall ? done_q : 1'b0;
    coord_clear = 1'b0;
    coord_step  = 1'b0;
    tile_valid  = (state_q == ISSUE);
    load_bias   = (state_q == ISSUE);
    feed_en     = (state_q == FEED) && buf_ready && !stall;
    sta_stall   = stall || ((state_q == FEED) && !buf_ready);
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rows_d      = cfg_out_rows;
            cols_d      = cfg_out_cols;
            nch_d       = cfg_num_ch;
            kb_d        = cfg_k_beats;
            busy_d      = 1'b1;
            coord_clear = 1'b1;
            if (cfg_out_rows == '0 || cfg_out_cols == '0 || cfg_num_ch == '0 || cfg_k_beats == '0)
              state_d = FIN;
            else
              state_d = ISSUE;
          end
        end
        ISSUE: begin
          beat_d  = '0;
          state_d = FEED;
        end
        FEED: begin
          if (buf_ready) begin
            if (beat_q == kb_q - K_BITS'(1)) begin
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              beat_d = beat_q + K_BITS'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_q == D_BITS'(DRAIN_CYCLES - 1))
            state_d = NEXT;
          else
            drain_d = drain_q + D_BITS'(1);
        end
        NEXT: begin
          coord_step = 1'b1;
          state_d    = coord_last ? FIN : ISSUE;
        end
        FIN: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, latched layer config and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      nch_q   <= '0;
      kb_q    <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      nch_q   <= nch_d;
      kb_q    <= kb_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign tile_mat_size = rows_q;

`ifdef STA_SCHED_PERF_EN
  logic [31:0] pbusy_q, pbusy_d, pstall_q, pstall_d, pstarve_q, pstarve_d;
  logic        accept;

  // Saturating activity counters, cleared when a new layer is accepted.
  always_comb begin
    accept    = (state_q == IDLE) && start && !stall;
    pbusy_d   = pbusy_q;
    pstall_d  = pstall_q;
    pstarve_d = pstarve_q;
    if (accept) begin
      pbusy_d   = '0;
      pstall_d  = '0;
      pstarve_d = '0;
    end else begin
      if (busy_q)
        pbusy_d = sat_inc32(pbusy_q);
      if (busy_q && stall)
        pstall_d = sat_inc32(pstall_q);
      if ((state_q == FEED) && !buf_ready && !stall)
        pstarve_d = sat_inc32(pstarve_q);
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pbusy_q   <= '0;
      pstall_q  <= '0;
      pstarve_q <= '0;
    end else begin
      pbusy_q   <= pbusy_d;
      pstall_q  <= pstall_d;
      pstarve_q <= pstarve_d;
    end
  end

  assign perf_busy_cycles   = pbusy_q;
  assign perf_stall_cycles  = pstall_q;
  assign perf_starve_cycles = pstarve_q;
`endif

endmodule

// File: tb/tb_sta_tile_scheduler.sv
// tb/tb_sta_tile_scheduler.sv - self-checking bench for sta_tile_scheduler
module tb_sta_tile_scheduler;

  localparam int N_BITS  = 10;
  localparam int CH_BITS = 7;
  localparam int K_BITS  = 12;

  logic clk = 1'b0;
  logic reset, stall, start, buf_ready;
  logic [N_BITS-1:0]  cfg_out_rows, cfg_out_cols;
  logic [CH_BITS-1:0] cfg_num_ch;
  logic [K_BITS-1:0]  cfg_k_beats;
  logic busy, done, tile_valid, load_bias, feed_en, sta_stall;
  logic [N_BITS-1:0]  tile_mat_size, tile_pos_row, tile_pos_col;
  logic [CH_BITS-1:0] tile_channel;
`ifdef STA_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles, perf_starve_cycles;
`endif

  sta_tile_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .start         (start),
    .cfg_out_rows  (cfg_out_rows),
    .cfg_out_cols  (cfg_out_cols),
    .cfg_num_ch    (cfg_num_ch),
    .cfg_k_beats   (cfg_k_beats),
    .buf_ready     (buf_ready),
    .busy          (busy),
    .done          (done),
    .tile_valid    (tile_valid),
    .tile_mat_size (tile_mat_size),
    .tile_pos_row  (tile_pos_row),
    .tile_pos_col  (tile_pos_col),
    .tile_channel  (tile_channel),
    .load_bias     (load_bias),
    .feed_en       (feed_en),
    .sta_stall     (sta_stall)
`ifdef STA_SCHED_PERF_EN
    ,
    .perf_busy_cycles   (perf_busy_cycles),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_starve_cycles (perf_starve_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int rows; int cols; int nch; int k;
    int stall_s; int stall_l; int starve_s; int starve_l;
    int exp_tiles; int exp_lat; int exp_p0; int exp_tv;
  } vec_t;

  typedef struct { int row; int col; int ch; } tile_t;

  tile_t exp_q[$];
  vec_t  vecs[12];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit in_win(input int c, input int s, input int l);
    return (l > 0) && (c >= s) && (c < s + l);
  endfunction

  function automatic longint enc(input int r, input int c, input int ch);
    return (longint'(r) << 24) | (longint'(c) << 8) | longint'(ch);
  endfunction

  // Reference tile order: channel outermost, then rows, then cols, stepping by the array edge.
  task automatic build_model(input vec_t v);
    exp_q.delete();
    if (v.rows > 0 && v.cols > 0 && v.k > 0)
      for (int c = 0; c < v.nch; c++)
        for (int r = 0; r < v.rows; r += 4)
          for (int cc = 0; cc < v.cols; cc += 4)
            exp_q.push_back('{r, cc, c});
  endtask

  task automatic run_vec(input vec_t v, input bit rnd, input string tag);
    int cyc, limit, tiles_seen, feeds, sst, tv, dones, done_cyc, last_tile, p0, bad, extra;
    tile_t t;
    build_model(v);
    tiles_seen = 0; feeds = 0; sst = 0; tv = 0; dones = 0; done_cyc = -1;
    last_tile = -1; p0 = -1; bad = 0; extra = 0;
    limit = v.exp_tiles * (v.k + 12) * 4 + 60;
    @(negedge clk);
    cfg_out_rows = N_BITS'(v.rows);
    cfg_out_cols = N_BITS'(v.cols);
    cfg_num_ch   = CH_BITS'(v.nch);
    cfg_k_beats  = K_BITS'(v.k);
    start = 1'b1; stall = 1'b0; buf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= limit && (done_cyc < 0 || cyc <= done_cyc + 1)) begin
      if (rnd) begin
        stall     = ($urandom_range(0, 4) == 0);
        buf_ready = ($urandom_range(0, 3) != 0);
      end else begin
        stall     = in_win(cyc, v.stall_s, v.stall_l);
        buf_ready = !in_win(cyc, v.starve_s, v.starve_l);
      end
      #1;
      if (cyc == 1) check({tag, " busy_after_start"}, busy, 1);
      if (tile_valid) tv++;
      if (tile_valid != load_bias) bad++;
      if (feed_en) begin
        feeds++;
        if (!buf_ready || stall) bad++;
      end
      if (sta_stall) sst++;
      if (tile_valid && !stall) begin
        if (exp_q.size() == 0) extra++;
        else begin
          t = exp_q.pop_front();
          check({tag, " tile_coord"}, enc(int'(tile_pos_row), int'(tile_pos_col), int'(tile_channel)),
                enc(t.row, t.col, t.ch));
        end
        check({tag, " mat_size"}, tile_mat_size, v.rows);
        if (tiles_seen == 1) p0 = cyc - last_tile;
        last_tile = cyc;
        tiles_seen++;
      end
      if (done && !stall) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check({tag, " busy_at_done"}, busy, 0);
        end
      end
      if (!rnd && done_cyc >= 0 && cyc == done_cyc + 1)
        check({tag, " done_one_cycle"}, done, 0);
      @(negedge clk);
      cyc++;
    end
    stall = 1'b0; buf_ready = 1'b1;
    check({tag, " done_seen"}, (done_cyc >= 0), 1);
    check({tag, " tiles"}, tiles_seen, v.exp_tiles);
    check({tag, " unissued_tiles"}, exp_q.size() + extra, 0);
    check({tag, " feed_beats"}, feeds, v.exp_tiles * v.k);
    check({tag, " done_pulses"}, dones, 1);
    check({tag, " strobe_rules"}, bad, 0);
    if (!rnd) begin
      check({tag, " latency"}, done_cyc, v.exp_lat);
      check({tag, " tile_valid_cycles"}, tv, v.exp_tv);
      check({tag, " sta_stall_cycles"}, sst, v.stall_l + v.starve_l);
      if (v.exp_p0 > 0) check({tag, " tile_period"}, p0, v.exp_p0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " strobes"}, {tile_valid, load_bias, feed_en, sta_stall}, 0);
    check({tag, " coords"}, enc(int'(tile_pos_row), int'(tile_pos_col), int'(tile_channel)), 0);
    check({tag, " mat_size"}, tile_mat_size, 0);
  endtask

  initial begin
    int dcount;
    vec_t rv;
    vecs[0]  = '{8,   8,   2, 4, 0, 0, 0, 0,   8,  130, 16,   8};
    vecs[1]  = '{6,   5,   1, 2, 0, 0, 0, 0,   4,   58, 14,   4};
    vecs[2]  = '{4,   8,   1, 3, 0, 0, 3, 5,   2,   37, 20,   2};
    vecs[3]  = '{4,   8,   1, 2, 1, 3, 0, 0,   2,   33, 14,   5};
    vecs[4]  = '{4,   4,   0, 3, 0, 0, 0, 0,   0,    2,  0,   0};
    vecs[5]  = '{0,   5,   1, 2, 0, 0, 0, 0,   0,    2,  0,   0};
    vecs[6]  = '{5,   0,   1, 2, 0, 0, 0, 0,   0,    2,  0,   0};
    vecs[7]  = '{4,   4,   1, 0, 0, 0, 0, 0,   0,    2,  0,   0};
    vecs[8]  = '{1,   1,   1, 1, 0, 0, 0, 0,   1,   15,  0,   1};
    vecs[9]  = '{9,   4,   1, 1, 0, 0, 0, 0,   3,   41, 13,   3};
    vecs[10] = '{512, 4,   1, 1, 0, 0, 0, 0, 128, 1666, 13, 128};
    vecs[11] = '{4,   512, 1, 1, 0, 0, 0, 0, 128, 1666, 13, 128};

    reset = 1'b1; stall = 1'b0; start = 1'b0; buf_ready = 1'b1;
    cfg_out_rows = '0; cfg_out_cols = '0; cfg_num_ch = '0; cfg_k_beats = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset during the drain of the second tile aborts without a done pulse.
    @(negedge clk);
    cfg_out_rows = 10'd8; cfg_out_cols = 10'd8; cfg_num_ch = 7'd1; cfg_k_beats = 12'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    #1;
    check("abort pre_reset_col", tile_pos_col, 4);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("abort");
    reset = 1'b0;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (done || busy || tile_valid) dcount++;
    end
    check("abort idle_after_reset", dcount, 0);
    run_vec(vecs[1], 1'b0, "replay");

    for (int r = 0; r < 6; r++) begin
      rv.rows = $urandom_range(1, 13);
      rv.cols = $urandom_range(1, 13);
      rv.nch  = $urandom_range(1, 3);
      rv.k    = $urandom_range(1, 5);
      rv.stall_s = 0; rv.stall_l = 0; rv.starve_s = 0; rv.starve_l = 0;
      rv.exp_tiles = ((rv.rows + 3) / 4) * ((rv.cols + 3) / 4) * rv.nch;
      rv.exp_lat = 0; rv.exp_p0 = 0; rv.exp_tv = 0;
      run_vec(rv, 1'b1, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sta_tile_scheduler.md
Name: sta_tile_scheduler

Overview:
Sequences the 4x4 systolic tensor array and output coordinator across a whole output feature map.
- Walks output tiles in SA_N-aligned steps (col innermost, then row, then channel).
- Per tile, issues the start strobe with pos/channel/mat_size, a one-cycle load_bias pulse, and cfg_k_beats A/B feed beats from the input buffers.
- Waits a fixed drain time after feeding, then advances to the next tile.
- Sits between layer-config logic and the STA controller wrapper.

Parameters:
OC_MAX_N, 512, max feature-map dimension; coordinate width N_BITS = $clog2(OC_MAX_N+1)
NUM_CH, 64, max channels; CH_BITS = $clog2(NUM_CH+1)
SA_N, 4, systolic array edge; tile step
K_BITS, 12, width of beat counter
DRAIN_CYCLES, 10, cycles after last beat until tile results are captured (3*SA_N-2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stall  in  1  global pipeline stall
start  in  1  begin layer; sampled only in IDLE
cfg_out_rows  in  N_BITS  output rows
cfg_out_cols  in  N_BITS  output cols
cfg_num_ch  in  CH_BITS  output channels
cfg_k_beats  in  K_BITS  vector beats per tile (K/SA_VECTOR_WIDTH)
buf_ready  in  1  input buffers hold a valid A/B beat
busy  out  1  layer in progress
done  out  1  one-cycle pulse at layer end
tile_valid  out  1  one-cycle start strobe to output coordinator
tile_mat_size  out  N_BITS  registered cfg_out_rows
tile_pos_row  out  N_BITS  tile base row
tile_pos_col  out  N_BITS  tile base col
tile_channel  out  CH_BITS  tile channel
load_bias  out  1  one-cycle bias load into all PEs
feed_en  out  1  consume one A/B beat this cycle
sta_stall  out  1  stall | (FEED & ~buf_ready); drives STA and OC stall

Behaviour:
- Reset value of every output is 0; state goes to IDLE.
- Reset mid-layer aborts immediately; no done pulse.
- While stall=1, all state, counters and outputs hold. Pulses are not duplicated and not lost.
- IDLE:
  - start=1 latches cfg_*, zeroes row/col/ch, sets busy=1.
  - If rows, cols or num_ch is 0, or k_beats is 0: go to FIN.
  - Otherwise go to ISSUE.
  - start while busy is ignored.
- ISSUE (1 cycle): tile_valid=1 and load_bias=1; tile_* show current coordinates; go to FEED with beat_cnt=0.
- FEED:
  - feed_en = buf_ready & ~stall.
  - beat_cnt increments on each feed_en.
  - At the beat where beat_cnt==k_beats-1 and feed_en=1, go to DRAIN with drain_cnt=0.
  - buf_ready=0 asserts sta_stall and holds the beat count.
- DRAIN: drain_cnt counts to DRAIN_CYCLES-1, then goes to NEXT.
- NEXT (1 cycle), advance in this priority order:
  - col += SA_N.
  - If col >= cols: col = 0, row += SA_N.
  - If row >= rows: row = 0, ch += 1.
  - If ch == num_ch: go to FIN; otherwise go to ISSUE.
  - Partial edge tiles are issued normally; the OC masks out-of-range PEs.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Arithmetic: coordinate adds use N_BITS+1 bits so the compare against the limit cannot wrap at OC_MAX_N.
- Tile latency from ISSUE to the next ISSUE, with no stalls: 1 + k_beats + DRAIN_CYCLES + 1 cycles.
- Tile count per layer: ceil(rows/SA_N) * ceil(cols/SA_N) * num_ch.

Optional Feature:
STA_SCHED_PERF_EN
- Defined: adds 32-bit saturating outputs perf_busy_cycles, perf_stall_cycles (stall=1 while busy) and perf_starve_cycles (FEED & ~buf_ready & ~stall). All clear on start acceptance and on reset.
- Undefined: these ports and counters are absent; the rest of the interface is unchanged.

Decomposition:
- Shared package: state enum sched_state_t {IDLE, ISSUE, FEED, DRAIN, NEXT, FIN}, the SA_N constant, and N_BITS/CH_BITS width typedefs. These live alongside int8_t/int32_t in sys_types.
- Sub-module tile_coord_counter: nested col/row/ch stepper with step, wrap limits and a last flag. It is reused later by the maxpool sequencer.

Test Plan:
- rows=8, cols=8, ch=2, k=4, buf_ready=1, no stall -> 8 tile_valid pulses at (0,0,0),(0,4,0),(4,0,0),(4,4,0), then the same for ch=1; 16 cycles between consecutive tile_valid; done once.
- rows=6, cols=5, ch=1, k=2 -> 4 tiles at (0,0),(0,4),(4,0),(4,4); done after the 4th drain.
- k=3, buf_ready low for 5 cycles mid-FEED -> sta_stall=1 for those 5 cycles, feed_en asserted exactly 3 times total, tile period grows by 5.
- stall=1 for 3 cycles coinciding with ISSUE -> tile_valid and load_bias stay high through the stall and count as one pulse; drain count is unaffected.
- cfg_num_ch=0 with start -> no tile_valid; busy high 1 cycle, done pulse 2 cycles after start.
- reset asserted during DRAIN of tile 2 -> all outputs 0 next cycle and no done; a new start replays from (0,0,0).
